// File: rtl/ahb_switch_in_db.sv
// AHB-Lite slave for NUM_IN switch inputs: synchronise, debounce, edge events, W1C status and a level IRQ.
// Optional IRQ_MASK register at 0x14 when SWITCH_IN_IRQ_MASK_EN is defined.
module ahb_switch_in_db #(
  parameter int NUM_IN          = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic [31:0]       HRDATA,
  output logic              SWITCH_IRQ,
  input  logic [NUM_IN-1:0] SWITCH
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_RISE   = 3'd1;
  localparam logic [2:0] ADDR_FALL   = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_RAW    = 3'd4;
`ifdef SWITCH_IN_IRQ_MASK_EN
  localparam logic [2:0] ADDR_MASK   = 3'd5;
`endif

  logic [NUM_IN-1:0] r_sync [SYNC_STAGES];
  logic [NUM_IN-1:0] r_deb;
  logic [NUM_IN-1:0] r_rise_en;
  logic [NUM_IN-1:0] r_fall_en;
  logic [NUM_IN-1:0] r_status;
  logic [CW-1:0]     r_cnt [NUM_IN];
  logic              r_dp_valid;
  logic              r_dp_write;
  logic [2:0]        r_dp_addr;

  logic [NUM_IN-1:0] w_sync;
  logic [NUM_IN-1:0] w_differ;
  logic [NUM_IN-1:0] w_flip;
  logic [NUM_IN-1:0] w_set;
  logic [NUM_IN-1:0] w_w1c;
  logic [NUM_IN-1:0] w_rdata;
  logic              w_wr;
  logic              w_unused;

  assign HREADYOUT = 1'b1;
  assign w_unused  = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

  // Synchroniser chain; the last stage is the RAW view.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= SWITCH;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_differ = w_sync ^ r_deb;

  always_comb begin
    w_flip = '0;
    for (int i = 0; i < NUM_IN; i++) w_flip[i] = w_differ[i] && (r_cnt[i] == CNT_MAX);
  end

  // A level is accepted on the DEBOUNCE_CYCLES-th consecutive differing cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_deb <= '0;
      for (int i = 0; i < NUM_IN; i++) r_cnt[i] <= '0;
    end else begin
      r_deb <= r_deb ^ w_flip;
      for (int i = 0; i < NUM_IN; i++) begin
        if (!w_differ[i] || w_flip[i]) r_cnt[i] <= '0;
        else                           r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  // Address phase capture; the data phase completes on the next HREADY edge.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_addr  <= '0;
    end else if (HREADY) begin
      r_dp_valid <= HSEL & HTRANS[1];
      r_dp_write <= HWRITE;
      r_dp_addr  <= HADDR[4:2];
    end
  end

  assign w_wr  = r_dp_valid & r_dp_write & HREADY;
  assign w_w1c = (w_wr && r_dp_addr == ADDR_STATUS) ? HWDATA[NUM_IN-1:0] : '0;
  // After a flip, deb equals sync, so sync gives the edge direction.
  assign w_set = (w_flip & w_sync & r_rise_en) | (w_flip & ~w_sync & r_fall_en);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_status  <= '0;
    end else begin
      if (w_wr && r_dp_addr == ADDR_RISE) r_rise_en <= HWDATA[NUM_IN-1:0];
      if (w_wr && r_dp_addr == ADDR_FALL) r_fall_en <= HWDATA[NUM_IN-1:0];
      r_status <= (r_status & ~w_w1c) | w_set;
    end
  end

`ifdef SWITCH_IN_IRQ_MASK_EN
  logic [NUM_IN-1:0] r_irq_mask;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                            r_irq_mask <= '0;
    else if (w_wr && r_dp_addr == ADDR_MASK) r_irq_mask <= HWDATA[NUM_IN-1:0];
  end

  assign SWITCH_IRQ = |(r_status & r_irq_mask);
`else
  assign SWITCH_IRQ = |r_status;
`endif

  always_comb begin
    w_rdata = '0;
    case (r_dp_addr)
      ADDR_DATA:   w_rdata = r_deb;
      ADDR_RISE:   w_rdata = r_rise_en;
      ADDR_FALL:   w_rdata = r_fall_en;
      ADDR_STATUS: w_rdata = r_status;
      ADDR_RAW:    w_rdata = w_sync;
`ifdef SWITCH_IN_IRQ_MASK_EN
      ADDR_MASK:   w_rdata = r_irq_mask;
`endif
      default:     w_rdata = '0;
    endcase
  end

  always_comb begin
    HRDATA = '0;
    if (r_dp_valid && !r_dp_write) HRDATA[NUM_IN-1:0] = w_rdata;
  end

endmodule

// File: tb/tb_ahb_switch_in_db.sv
// Directed bench for ahb_switch_in_db (NUM_IN=16, DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
module tb_ahb_switch_in_db;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        SWITCH_IRQ;
  logic [15:0] SWITCH;

  int n_total = 0;
  int n_bad   = 0;

  ahb_switch_in_db #(.NUM_IN(16), .DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRDATA(HRDATA), .SWITCH_IRQ(SWITCH_IRQ), .SWITCH(SWITCH)
  );

  always #5 HCLK = ~HCLK;

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    tick(1);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    tick(1);
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    tick(1);
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
    tick(1);
  endtask

  task automatic test_reset();
    logic [31:0] exp_d;
    logic [31:0] rd;
    HRESETn = 1'b0; SWITCH = 16'hFFFF;
    HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = '0; HREADY = 1'b1;
    tick(3);
    n_total++; if (HRDATA !== 32'h0) begin n_bad++; $display("FAIL rst_hrdata got=%h exp=%h", HRDATA, 32'h0); end
    n_total++; if (SWITCH_IRQ !== 1'b0) begin n_bad++; $display("FAIL rst_irq got=%b exp=0", SWITCH_IRQ); end
    n_total++; if (HREADYOUT !== 1'b1) begin n_bad++; $display("FAIL rst_hreadyout got=%b exp=1", HREADYOUT); end
    // Continuous DATA reads from release: level appears after edge 6.
    HRESETn = 1'b1; HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h00;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      exp_d = (k >= 6) ? 32'h0000FFFF : 32'h0;
      n_total++;
      if (HRDATA !== exp_d) begin n_bad++; $display("FAIL rst_latency k=%0d got=%h exp=%h", k, HRDATA, exp_d); end
    end
    HSEL = 1'b0; HTRANS = 2'b00;
    tick(1);
    ahb_read(32'h0C, rd);
    n_total++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rst_status got=%h exp=%h", rd, 32'h0); end
    n_total++; if (SWITCH_IRQ !== 1'b0) begin n_bad++; $display("FAIL rst_irq_after got=%b exp=0", SWITCH_IRQ); end
    SWITCH = 16'h0000;
    tick(10);
    ahb_read(32'h00, rd);
    n_total++; if (rd !== 32'h0) begin n_bad++; $display("FAIL data_low got=%h exp=%h", rd, 32'h0); end
  endtask

  task automatic test_rise_glitch();
    logic [31:0] rd;
    ahb_write(32'h04, 32'h0001);
    SWITCH = 16'h0001;
    tick(3);
    SWITCH = 16'h0000;
    tick(10);
    n_total++; if (SWITCH_IRQ !== 1'b0) begin n_bad++; $display("FAIL glitch_irq got=%b exp=0", SWITCH_IRQ); end
    ahb_read(32'h00, rd);
    n_total++; if (rd !== 32'h0) begin n_bad++; $display("FAIL glitch_data got=%h exp=%h", rd, 32'h0); end
    ahb_read(32'h0C, rd);
    n_total++; if (rd !== 32'h0) begin n_bad++; $display("FAIL glitch_status got=%h exp=%h", rd, 32'h0); end
    SWITCH = 16'h0001;
    tick(10);
    n_total++; if (SWITCH_IRQ !== 1'b1) begin n_bad++; $display("FAIL rise_irq got=%b exp=1", SWITCH_IRQ); end
    ahb_read(32'h00, rd);
    n_total++; if (rd !== 32'h1) begin n_bad++; $display("FAIL rise_data got=%h exp=%h", rd, 32'h1); end
    ahb_read(32'h0C, rd);
    n_total++; if (rd !== 32'h1) begin n_bad++; $display("FAIL rise_status got=%h exp=%h", rd, 32'h1); end
  endtask

  task automatic test_fall_w1c();
    logic [31:0] rd;
    ahb_write(32'h08, 32'h0008);
    SWITCH = 16'h0009;
    tick(10);
    ahb_write(32'h0C, 32'h0001);
    n_total++; if (SWITCH_IRQ !== 1'b0) begin n_bad++; $display("FAIL clr0_irq got=%b exp=0", SWITCH_IRQ); end
    ahb_read(32'h08, rd);
    n_total++; if (rd !== 32'h8) begin n_bad++; $display("FAIL fall_en_rd got=%h exp=%h", rd, 32'h8); end
    SWITCH = 16'h0001;
    tick(5);
    n_total++; if (SWITCH_IRQ !== 1'b0) begin n_bad++; $display("FAIL fall_early got=%b exp=0", SWITCH_IRQ); end
    tick(1);
    n_total++; if (SWITCH_IRQ !== 1'b1) begin n_bad++; $display("FAIL fall_edge got=%b exp=1", SWITCH_IRQ); end
    ahb_read(32'h0C, rd);
    n_total++; if (rd !== 32'h8) begin n_bad++; $display("FAIL fall_status got=%h exp=%h", rd, 32'h8); end
    ahb_write(32'h0C, 32'h0001);
    ahb_read(32'h0C, rd);
    n_total++; if (rd !== 32'h8) begin n_bad++; $display("FAIL w1c_zero_bits got=%h exp=%h", rd, 32'h8); end
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0C;
    tick(1);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h0008;
    n_total++; if (SWITCH_IRQ !== 1'b1) begin n_bad++; $display("FAIL w1c_before got=%b exp=1", SWITCH_IRQ); end
    tick(1);
    n_total++; if (SWITCH_IRQ !== 1'b0) begin n_bad++; $display("FAIL w1c_after got=%b exp=0", SWITCH_IRQ); end
    ahb_read(32'h0C, rd);
    n_total++; if (rd !== 32'h0) begin n_bad++; $display("FAIL w1c_status got=%h exp=%h", rd, 32'h0); end
  endtask

  task automatic test_set_wins();
    logic [31:0] rd;
    SWITCH = 16'h0000;
    tick(10);
    ahb_read(32'h0C, rd);
    n_total++; if (rd !== 32'h0) begin n_bad++; $display("FAIL setwin_pre got=%h exp=%h", rd, 32'h0); end
    // Rising event lands on edge 6; the W1C data phase is timed onto that edge.
    SWITCH = 16'h0001;
    tick(4);
    ahb_write(32'h0C, 32'h0001);
    n_total++; if (SWITCH_IRQ !== 1'b1) begin n_bad++; $display("FAIL setwin_irq got=%b exp=1", SWITCH_IRQ); end
    ahb_read(32'h0C, rd);
    n_total++; if (rd !== 32'h1) begin n_bad++; $display("FAIL setwin_status got=%h exp=%h", rd, 32'h1); end
    ahb_write(32'h0C, 32'h0001);
    n_total++; if (SWITCH_IRQ !== 1'b0) begin n_bad++; $display("FAIL clr1_irq got=%b exp=0", SWITCH_IRQ); end
    ahb_read(32'h0C, rd);
    n_total++; if (rd !== 32'h0) begin n_bad++; $display("FAIL clr1_status got=%h exp=%h", rd, 32'h0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h04;
    tick(1);
    HWDATA = 32'h000000A5; HWRITE = 1'b0; HADDR = 32'h04;
    tick(1);
    HSEL = 1'b0; HTRANS = 2'b00;
    n_total++; if (HRDATA !== 32'hA5) begin n_bad++; $display("FAIL b2b_read got=%h exp=%h", HRDATA, 32'hA5); end
    n_total++; if (HREADYOUT !== 1'b1) begin n_bad++; $display("FAIL b2b_hreadyout got=%b exp=1", HREADYOUT); end
    tick(1);
    ahb_read(32'h18, rd);
    n_total++; if (rd !== 32'h0) begin n_bad++; $display("FAIL unmapped_rd got=%h exp=%h", rd, 32'h0); end
    ahb_write(32'h1C, 32'hFFFFFFFF);
    ahb_read(32'h04, rd);
    n_total++; if (rd !== 32'hA5) begin n_bad++; $display("FAIL unmapped_wr got=%h exp=%h", rd, 32'hA5); end
    ahb_read(32'h10, rd);
    n_total++; if (rd !== 32'h1) begin n_bad++; $display("FAIL raw_rd got=%h exp=%h", rd, 32'h1); end
    ahb_write(32'h00, 32'h0000FFFF);
    ahb_read(32'h00, rd);
    n_total++; if (rd !== 32'h1) begin n_bad++; $display("FAIL data_ro got=%h exp=%h", rd, 32'h1); end
  endtask

  task automatic test_irq_mask();
    logic [31:0] rd;
    ahb_write(32'h04, 32'h0004);
`ifdef SWITCH_IN_IRQ_MASK_EN
    ahb_write(32'h14, 32'h0000);
    SWITCH = 16'h0005;
    tick(10);
    ahb_read(32'h0C, rd);
    n_total++; if (rd !== 32'h4) begin n_bad++; $display("FAIL mask_status got=%h exp=%h", rd, 32'h4); end
    n_total++; if (SWITCH_IRQ !== 1'b0) begin n_bad++; $display("FAIL mask_irq_off got=%b exp=0", SWITCH_IRQ); end
    ahb_write(32'h14, 32'h0004);
    n_total++; if (SWITCH_IRQ !== 1'b1) begin n_bad++; $display("FAIL mask_irq_on got=%b exp=1", SWITCH_IRQ); end
    ahb_read(32'h14, rd);
    n_total++; if (rd !== 32'h4) begin n_bad++; $display("FAIL mask_rd got=%h exp=%h", rd, 32'h4); end
`else
    SWITCH = 16'h0005;
    tick(10);
    ahb_read(32'h0C, rd);
    n_total++; if (rd !== 32'h4) begin n_bad++; $display("FAIL nomask_status got=%h exp=%h", rd, 32'h4); end
    n_total++; if (SWITCH_IRQ !== 1'b1) begin n_bad++; $display("FAIL nomask_irq got=%b exp=1", SWITCH_IRQ); end
    ahb_write(32'h14, 32'h0000FFFF);
    ahb_read(32'h14, rd);
    n_total++; if (rd !== 32'h0) begin n_bad++; $display("FAIL nomask_rd got=%h exp=%h", rd, 32'h0); end
`endif
  endtask

  initial begin
    test_reset();
    test_rise_glitch();
    test_fall_w1c();
    test_set_wins();
    test_back_to_back();
    test_irq_mask();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
